// File: rtl/lvds_tx_if.sv
// FIFO-read and DDR-output signal bundle for the LVDS transmit serializer.
// The master side drives the FIFO status/data; the slave side is the serializer.
interface lvds_tx_if;
    logic        i_enable;
    logic        i_fifo_empty;
    logic [31:0] i_fifo_data;
    logic        o_fifo_pull;
    logic [1:0]  o_ddr_data;
    logic        o_busy;
    logic [7:0]  o_underrun_count;

    modport master (
        output i_enable, i_fifo_empty, i_fifo_data,
        input  o_fifo_pull, o_ddr_data, o_busy, o_underrun_count
    );

    modport slave (
        input  i_enable, i_fifo_empty, i_fifo_data,
        output o_fifo_pull, o_ddr_data, o_busy, o_underrun_count
    );
endinterface

// File: rtl/lvds_tx.sv
// LVDS TX serializer: 32-bit I/Q words out MSB-first as 16 DDR bit-pairs.
// Optional macro LVDS_TX_SYNC_INSERT_EN forces I/Q sync bits into every loaded word.
module lvds_tx #(
    parameter int FIFO_RD_LATENCY = 1
) (
    input  logic     i_ddr_clk,
    input  logic     i_reset,
    lvds_tx_if.slave bus
);
    localparam logic [3:0]  PREFETCH_PAIR = 4'(14 - FIFO_RD_LATENCY);
    localparam logic [31:0] UNDERRUN_WORD = 32'h0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic                       r_pull;
    logic [FIFO_RD_LATENCY-1:0] r_pull_dly;
    logic [FIFO_RD_LATENCY-1:0] w_pull_dly_next;
    logic [31:0]                r_shift;
    logic [1:0]                 r_ddr;
    logic [3:0]                 r_pair;
    logic                       r_busy;
    logic [7:0]                 r_underrun;
    logic                       w_data_valid;
    logic                       w_outstanding;
    logic                       w_boundary;
    logic                       w_pull_next;
    logic                       w_load;
    logic                       w_underrun;
    logic [31:0]                w_raw_word;
    logic [31:0]                w_load_word;

    // Pull strobe delayed by the FIFO read latency marks the cycle data is valid.
    assign w_pull_dly_next[0] = r_pull;
    genvar gi;
    generate
        for (gi = 1; gi < FIFO_RD_LATENCY; gi++) begin : g_pull_dly
            assign w_pull_dly_next[gi] = r_pull_dly[gi-1];
        end
    endgenerate

    assign w_data_valid  = r_pull_dly[FIFO_RD_LATENCY-1];
    assign w_outstanding = r_pull | (|r_pull_dly);
    assign w_boundary    = (r_state == ST_RUN) && (r_pair == 4'd15);
    assign w_raw_word    = w_data_valid ? bus.i_fifo_data : UNDERRUN_WORD;

`ifdef LVDS_TX_SYNC_INSERT_EN
    assign w_load_word = {2'b10, w_raw_word[29:16], 2'b01, w_raw_word[13:0]};
`else
    assign w_load_word = w_raw_word;
`endif

    always_ff @(posedge i_ddr_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // An outstanding PRIME read is always completed so a pulled word is never lost.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_enable) w_state_next = ST_PRIME;
            end
            ST_PRIME: begin
                if (w_data_valid)                          w_state_next = ST_RUN;
                else if (!bus.i_enable && !w_outstanding)  w_state_next = ST_IDLE;
            end
            ST_RUN: begin
                if (w_boundary && !w_data_valid && !bus.i_enable) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_pull_next = 1'b0;
        w_load      = 1'b0;
        w_underrun  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_pull_next = bus.i_enable && !bus.i_fifo_empty;
            end
            ST_PRIME: begin
                w_pull_next = bus.i_enable && !bus.i_fifo_empty && !w_outstanding;
                w_load      = w_data_valid;
            end
            ST_RUN: begin
                w_pull_next = (r_pair == PREFETCH_PAIR) && bus.i_enable && !bus.i_fifo_empty;
                if (w_boundary) begin
                    w_load     = w_data_valid || bus.i_enable;
                    w_underrun = !w_data_valid && bus.i_enable;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_ddr_clk) begin
        if (i_reset) begin
            r_pull     <= 1'b0;
            r_pull_dly <= '0;
            r_shift    <= 32'h0;
            r_ddr      <= 2'b00;
            r_pair     <= 4'd0;
            r_busy     <= 1'b0;
            r_underrun <= 8'd0;
        end else begin
            r_pull     <= w_pull_next;
            r_pull_dly <= w_pull_dly_next;
            r_busy     <= (w_state_next != ST_IDLE);
            if (w_load) begin
                r_ddr   <= w_load_word[31:30];
                r_shift <= {w_load_word[29:0], 2'b00};
                r_pair  <= 4'd0;
            end else if (r_state == ST_RUN && !w_boundary) begin
                r_ddr   <= r_shift[31:30];
                r_shift <= {r_shift[29:0], 2'b00};
                r_pair  <= r_pair + 4'd1;
            end else begin
                r_ddr   <= 2'b00;
                r_pair  <= 4'd0;
            end
            if (w_underrun && (r_underrun != 8'hFF)) begin
                r_underrun <= r_underrun + 8'd1;
            end
        end
    end

    assign bus.o_fifo_pull      = r_pull;
    assign bus.o_ddr_data       = r_ddr;
    assign bus.o_busy           = r_busy;
    assign bus.o_underrun_count = r_underrun;
endmodule

// File: tb/tb_lvds_tx.sv
// Bench for lvds_tx: L=1 and L=2 instances share stimulus, each fed by its own FIFO
// model and compared every cycle against a timestamp-based word-level reference.
module tb_lvds_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    always #5 clk = ~clk;

    lvds_tx_if bus0();
    lvds_tx_if bus1();

    lvds_tx #(.FIFO_RD_LATENCY(1)) dut0 (.i_ddr_clk(clk), .i_reset(rst), .bus(bus0));
    lvds_tx #(.FIFO_RD_LATENCY(2)) dut1 (.i_ddr_clk(clk), .i_reset(rst), .bus(bus1));

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit armed = 1'b0;
    int pulls1;

    logic [31:0] words[$];
    int          fifo_rd[2];
    int          model_rd[2];
    int          ret_cyc[2];
    logic [31:0] ret_word[2];

    int          m_mode[2];
    int          m_start[2];
    int          m_pull_cyc[2];
    int          m_cnt[2];
    logic        m_pend[2];
    logic [31:0] m_word[2];
    logic [31:0] m_pend_word[2];
    logic [1:0]  e_ddr[2];
    logic        e_pull[2];
    logic        e_busy[2];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] sync_w(input logic [31:0] w);
        logic [31:0] r;
        r = w;
`ifdef LVDS_TX_SYNC_INSERT_EN
        r[31:30] = 2'b10;
        r[15:14] = 2'b01;
`endif
        return r;
    endfunction

    function automatic logic [1:0] pair_of(input logic [31:0] w, input int k);
        logic [31:0] s;
        s = w >> (30 - 2 * k);
        return s[1:0];
    endfunction

    task automatic take_word(input int d, input int n);
        m_pend[d]      = 1'b1;
        m_pull_cyc[d]  = n + 1;
        m_pend_word[d] = (model_rd[d] < words.size()) ? words[model_rd[d]] : 32'h0;
        model_rd[d]++;
    endtask

    task automatic load_word(input int d, input logic [31:0] w, input int n);
        logic [31:0] sw;
        sw         = sync_w(w);
        m_word[d]  = sw;
        m_start[d] = n + 1;
        m_pend[d]  = 1'b0;
        e_ddr[d]   = sw[31:30];
        $display("word dut%0d start_cycle=%0d value=%h", d, n + 1, sw);
    endtask

    // Reference: word timing from pull timestamps; pair index is cycle minus word start.
    task automatic model_step(input int d, input logic empty, input int n);
        int lat;
        int k;
        lat = d + 1;
        e_pull[d] = 1'b0;
        if (rst) begin
            m_mode[d] = 0;
            m_cnt[d]  = 0;
            m_pend[d] = 1'b0;
            e_ddr[d]  = 2'b00;
        end else if (m_mode[d] == 0) begin
            e_ddr[d] = 2'b00;
            if (en) begin
                m_mode[d] = 1;
                if (!empty) begin
                    e_pull[d] = 1'b1;
                    take_word(d, n);
                end
            end
        end else if (m_mode[d] == 1) begin
            e_ddr[d] = 2'b00;
            if (m_pend[d] && n == m_pull_cyc[d] + lat) begin
                load_word(d, m_pend_word[d], n);
                m_mode[d] = 2;
            end else if (!m_pend[d] && !en) begin
                m_mode[d] = 0;
            end else if (!m_pend[d] && !empty) begin
                e_pull[d] = 1'b1;
                take_word(d, n);
            end
        end else begin
            k = n - m_start[d];
            if (k == 14 - lat && en && !empty) begin
                e_pull[d] = 1'b1;
                take_word(d, n);
            end
            if (k == 15) begin
                if (m_pend[d]) begin
                    load_word(d, m_pend_word[d], n);
                end else if (en) begin
                    load_word(d, 32'h0, n);
                    if (m_cnt[d] < 255) m_cnt[d]++;
                end else begin
                    m_mode[d] = 0;
                    e_ddr[d]  = 2'b00;
                end
            end else begin
                e_ddr[d] = pair_of(m_word[d], k + 1);
            end
        end
        e_busy[d] = (m_mode[d] != 0);
    endtask

    task automatic tick();
        logic [1:0]  a_ddr[2];
        logic        a_pull[2];
        logic        a_busy[2];
        logic [7:0]  a_cnt[2];
        logic        empty[2];
        logic [31:0] data[2];
        a_ddr[0] = bus0.o_ddr_data;  a_ddr[1] = bus1.o_ddr_data;
        a_pull[0] = bus0.o_fifo_pull; a_pull[1] = bus1.o_fifo_pull;
        a_busy[0] = bus0.o_busy;     a_busy[1] = bus1.o_busy;
        a_cnt[0] = bus0.o_underrun_count; a_cnt[1] = bus1.o_underrun_count;
        for (int d = 0; d < 2; d++) begin
            if (armed) begin
                check_val($sformatf("ddr_L%0d", d + 1), a_ddr[d], e_ddr[d]);
                check_val($sformatf("pull_L%0d", d + 1), a_pull[d], e_pull[d]);
                check_val($sformatf("busy_L%0d", d + 1), a_busy[d], e_busy[d]);
                check_val($sformatf("urun_L%0d", d + 1), a_cnt[d], m_cnt[d]);
            end
            if (a_pull[d]) begin
                ret_word[d] = (fifo_rd[d] < words.size()) ? words[fifo_rd[d]] : $urandom;
                fifo_rd[d]++;
                ret_cyc[d] = cyc + d + 1;
            end
            empty[d] = (fifo_rd[d] >= words.size());
            data[d]  = (ret_cyc[d] == cyc) ? ret_word[d] : $urandom;
        end
        bus0.i_enable = en; bus0.i_fifo_empty = empty[0]; bus0.i_fifo_data = data[0];
        bus1.i_enable = en; bus1.i_fifo_empty = empty[1]; bus1.i_fifo_data = data[1];
        for (int d = 0; d < 2; d++) model_step(d, empty[d], cyc);
        armed = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            fifo_rd[d] = 0; model_rd[d] = 0; ret_cyc[d] = -1; ret_word[d] = 32'h0;
            m_mode[d] = 0; m_start[d] = 0; m_pull_cyc[d] = 0; m_cnt[d] = 0;
            m_pend[d] = 1'b0; m_word[d] = 32'h0; m_pend_word[d] = 32'h0;
            e_ddr[d] = 2'b00; e_pull[d] = 1'b0; e_busy[d] = 1'b0;
        end
        bus0.i_enable = 1'b0; bus0.i_fifo_empty = 1'b1; bus0.i_fifo_data = 32'h0;
        bus1.i_enable = 1'b0; bus1.i_fifo_empty = 1'b1; bus1.i_fifo_data = 32'h0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (4) tick();

        // First word, back-to-back pair, then underruns while enable stays high
        words.push_back(32'hA5A5_0F0F);
        words.push_back(32'h1234_5678);
        words.push_back(32'h9ABC_DEF0);
        en = 1'b1;
        repeat (90) tick();
        en = 1'b0;
        repeat (40) tick();

        // Drop enable the cycle after the L=2 prefetch pull
        words.push_back($urandom);
        words.push_back($urandom);
        en = 1'b1;
        pulls1 = 0;
        for (int i = 0; i < 200 && pulls1 < 2; i++) begin
            if (bus1.o_fifo_pull) pulls1++;
            if (pulls1 < 2) tick();
        end
        check_val("pull2_wait", pulls1, 2);
        tick();
        en = 1'b0;
        repeat (60) tick();

        // Randomized enable toggling and FIFO refill
        repeat (40) begin
            int nw;
            nw = $urandom_range(0, 2);
            repeat (nw) words.push_back($urandom);
            en = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(3, 40)) tick();
        end

        // Reset in the middle of a word, then re-prime
        en = 1'b1;
        repeat (3) words.push_back($urandom);
        repeat (25) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (50) tick();

        // Long underrun run saturates the counter
        words.push_back($urandom);
        en = 1'b1;
        repeat (16 * 300) tick();
        check_val("urun_sat_L1", bus0.o_underrun_count, 32'd255);
        check_val("urun_sat_L2", bus1.o_underrun_count, 32'd255);
        en = 1'b0;
        repeat (40) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
